fcel_tile: RTL and testbench



---
 rtl/fcel_tile.sv | 81 ++++++++
 tb/tb_fcel_tile.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fcel_tile.sv
`default_nettype none
// ============================================================================
//  Module   : fcel_tile
//  Brief    : Configurable fabric tile: 4-input LUT with optional output
//             flip-flop and 32:1 routing multiplexers feeding 4 connection-box
//             outputs (with per-bit inversion) and 12 switch-box outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module fcel_tile (
   input  logic         clk,
   input  logic         rst,
   input  logic [123:0] ctrs,
   input  logic [3:0]   cbis,
   input  logic [11:0]  sbis,
   output logic [3:0]   cbos,
   output logic [11:0]  sbos
);

   // Configuration field positions
   localparam int c_lut_sel_lsb = 16;
   localparam int c_mode_bit    = 32;
   localparam int c_cb_sel_lsb  = 33;
   localparam int c_sb_sel_lsb  = 53;
   localparam int c_init_bit    = 113;
   localparam int c_en_bit      = 114;
   localparam int c_inv_lsb     = 115;

   logic [15:0] w_ext;      // external sources S[0..15]
   logic [15:0] w_tt;       // LUT truth table
   logic [3:0]  w_lut_in;   // LUT address {in3,in2,in1,in0}
   logic        w_lut;      // combinational LUT output
   logic        w_cell;     // cell output (registered or combinational)
   logic [31:0] w_src;      // full routing source space S[0..31]
   logic        r_ff;       // LUT output register

   // Reserved configuration bits are intentionally ignored.
   logic w_unused_rsvd;
   assign w_unused_rsvd = ^ctrs[123:119];

   assign w_ext = {sbis, cbis};
   assign w_tt  = ctrs[15:0];

   // LUT inputs are drawn only from external sources, which keeps the tile
   // free of combinational loops regardless of how outputs are routed.
   generate
      for (genvar k = 0; k < 4; k++) begin : g_lut_in
         assign w_lut_in[k] = w_ext[ctrs[c_lut_sel_lsb + 4*k +: 4]];
      end
   endgenerate

   assign w_lut  = w_tt[w_lut_in];
   assign w_cell = ctrs[c_mode_bit] ? r_ff : w_lut;

   // Codes 20..31 are constant 0, code 19 constant 1.
   assign w_src = {12'b0, 1'b1, r_ff, w_lut, w_cell, w_ext};

   // LUT output register: async load of the init value, capture when enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ff <= ctrs[c_init_bit];
      end else if (ctrs[c_en_bit]) begin
         r_ff <= w_lut;
      end
   end

   // Connection-box outputs with optional per-bit inversion.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_cbo
         assign cbos[i] = w_src[ctrs[c_cb_sel_lsb + 5*i +: 5]] ^ ctrs[c_inv_lsb + i];
      end
   endgenerate

   // Switch-box track outputs.
   generate
      for (genvar j = 0; j < 12; j++) begin : g_sbo
         assign sbos[j] = w_src[ctrs[c_sb_sel_lsb + 5*j +: 5]];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fcel_tile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fcel_tile
//  Brief    : Directed self-checking bench for fcel_tile.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fcel_tile;

   logic         clk;
   logic         rst;
   logic [123:0] ctrs;
   logic [3:0]   cbis;
   logic [11:0]  sbis;
   logic [3:0]   cbos;
   logic [11:0]  sbos;

   int total = 0;
   int bad   = 0;

   fcel_tile dut (
      .clk  (clk),
      .rst  (rst),
      .ctrs (ctrs),
      .cbis (cbis),
      .sbis (sbis),
      .cbos (cbos),
      .sbos (sbos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   logic [123:0] cfg;
   logic [15:0]  tt;

   initial begin
      // Reset with all-zero configuration
      rst  = 1'b1;
      ctrs = '0;
      cbis = '0;
      sbis = '0;
      #12;
      check("rst_cbos", {8'h0, cbos}, 12'h0);
      check("rst_sbos", sbos, 12'h0);
      rst = 1'b0;
      #100;
      check("idle_cbos", {8'h0, cbos}, 12'h0);
      check("idle_sbos", sbos, 12'h0);

      // Pass-through: every select is 0 -> all outputs follow cbis[0]
      ctrs = 124'd999;
      cbis = 4'd3;
      sbis = 12'd1;
      #1;
      check("pass_cbos", {8'h0, cbos}, 12'h00F);
      check("pass_sbos", sbos, 12'hFFF);
      ctrs = '0;
      cbis = '0;
      sbis = '0;
      #1;
      check("pass0_cbos", {8'h0, cbos}, 12'h0);
      check("pass0_sbos", sbos, 12'h0);

      // AND4 on cbis[0..3], sbos[0] shows lut_comb
      cfg = '0;
      cfg[15:0]  = 16'h8000;
      cfg[31:16] = 16'h3210;
      cfg[57:53] = 5'd17;
      ctrs = cfg;
      cbis = 4'hF;
      #1;
      check("and4_hi", {11'h0, sbos[0]}, 12'h1);
      cbis = 4'h7;
      #1;
      check("and4_lo", {11'h0, sbos[0]}, 12'h0);

      // Full address sweep against an arbitrary truth table
      tt = 16'hA5C3;
      cfg[15:0] = tt;
      ctrs = cfg;
      for (int a = 0; a < 16; a++) begin
         cbis = 4'(a);
         #1;
         check("lut_sweep", {11'h0, sbos[0]}, {11'h0, tt[a]});
      end

      // Registered mode: init=1, enable=1, cbos[0] shows cell_out
      cfg = '0;
      cfg[32]    = 1'b1;
      cfg[114]   = 1'b1;
      cfg[113]   = 1'b1;
      cfg[37:33] = 5'd16;
      cbis = '0;
      @(negedge clk);
      rst  = 1'b1;
      ctrs = cfg;
      #1;
      check("reg_rst", {11'h0, cbos[0]}, 12'h1);
      @(posedge clk); #1;
      check("reg_rst_hold", {11'h0, cbos[0]}, 12'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reg_release", {11'h0, cbos[0]}, 12'h1);
      @(posedge clk); #1;
      check("reg_capture0", {11'h0, cbos[0]}, 12'h0);
      // lut_comb=1: output waits for the clock
      @(negedge clk);
      cfg[15:0] = 16'hFFFF;
      ctrs = cfg;
      #1;
      check("reg_before_edge", {11'h0, cbos[0]}, 12'h0);
      @(posedge clk); #1;
      check("reg_capture1", {11'h0, cbos[0]}, 12'h1);
      // Enable off: value holds even though lut_comb is 0
      @(negedge clk);
      cfg[114]  = 1'b0;
      cfg[15:0] = 16'h0000;
      ctrs = cfg;
      repeat (3) @(posedge clk);
      #1;
      check("reg_hold", {11'h0, cbos[0]}, 12'h1);

      // Asynchronous reset between clock edges
      @(negedge clk);
      cfg[114] = 1'b1;
      ctrs = cfg;
      @(posedge clk); #1;
      check("async_pre", {11'h0, cbos[0]}, 12'h0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_set", {11'h0, cbos[0]}, 12'h1);
      @(posedge clk); #1;
      check("async_override", {11'h0, cbos[0]}, 12'h1);
      @(negedge clk);
      rst = 1'b0;

      // Bus reversal through switch-box selects
      cfg = '0;
      for (int j = 0; j < 12; j++) cfg[53 + 5*j +: 5] = 5'(15 - j);
      ctrs = cfg;
      sbis = 12'h001;
      #1;
      check("rev_001", sbos, 12'h800);
      sbis = 12'h123;
      #1;
      check("rev_123", sbos, 12'hC48);

      // Inversion on constant-0 sources, code 19 / code 31 on sbos
      cfg = '0;
      for (int i = 0; i < 4; i++)  cfg[33 + 5*i +: 5] = 5'd20;
      cfg[118:115] = 4'b1010;
      for (int j = 0; j < 12; j++) cfg[53 + 5*j +: 5] = 5'd31;
      cfg[57:53] = 5'd19;
      ctrs = cfg;
      cbis = 4'hF;
      sbis = 12'hFFF;
      #1;
      check("inv_cbos", {8'h0, cbos}, 12'h00A);
      check("const_sbos", sbos, 12'h001);

      // Reserved bits have no effect
      cfg[123:119] = 5'h1F;
      ctrs = cfg;
      #1;
      check("rsvd_cbos", {8'h0, cbos}, 12'h00A);
      check("rsvd_sbos", sbos, 12'h001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
